hedios_command_engine: RTL and testbench

Parametrised second-generation Hedios packet controller. Sits between the Hedios serial RX queue and TX queue inside an endpoint. Pops {command, data} packets, decodes them, reads slots, latches an action argument, pulses actions, writes control registers and drives device reset, then pushes one response packet per request. Adds over the first generation: generic data width, writable control registers, error responses, a lost-data report and a multi-cycle reset pulse.

---
 rtl/hedios_command_engine.sv | 254 +++++++++++++++++++++++++
 tb/tb_hedios_command_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hedios_command_engine.sv
// hedios_command_engine: Hedios second-generation packet controller.
// Pops {command, data} packets from the RX queue, executes them for one
// cycle and pushes exactly one response packet to the TX queue. Lost-data
// reports and unsolicited pings are injected ahead of queued packets.
// Optional build macro: HEDIOS_STATS_EN adds saturating ok/error counters
// read and cleared by command 0x07.
module hedios_command_engine #(
  parameter int         DATA_WIDTH       = 32,
  parameter int         SLOT_COUNT       = 4,
  parameter int         ACTION_COUNT     = 4,
  parameter int         CTRL_COUNT       = 2,
  parameter int         RST_PULSE_CYCLES = 16,
  parameter logic [7:0] VERSION          = 8'h02
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx_empty,
  input  logic                             rx_lost_data,
  input  logic [7:0]                       rx_command,
  input  logic [DATA_WIDTH-1:0]            rx_data,
  output logic                             rx_pop_packet,
  input  logic                             tx_full,
  output logic [7:0]                       tx_command,
  output logic [DATA_WIDTH-1:0]            tx_data,
  output logic                             tx_push_packet,
  input  logic                             send_ping,
  input  logic [SLOT_COUNT*DATA_WIDTH-1:0] slots,
  output logic [ACTION_COUNT-1:0]          actions,
  output logic [DATA_WIDTH-1:0]            action_argument,
  output logic [CTRL_COUNT*DATA_WIDTH-1:0] ctrl_regs,
  output logic                             rst_device,
  output logic [7:0]                       last_command,
  output logic                             busy
);

  localparam int CNT_W = $clog2(RST_PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_PULSE_CYCLES);
  localparam logic [31:0] PING_WORD = {VERSION, 8'h53, 8'h44, 8'h48};
  localparam logic [DATA_WIDTH-1:0] PING_DATA = DATA_WIDTH'(PING_WORD);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESPOND} state_t;

  state_t                          state_q, state_d;
  logic [7:0]                      cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0]           data_q, data_d;
  logic [7:0]                      last_cmd_q, last_cmd_d;
  logic [DATA_WIDTH-1:0]           arg_q, arg_d;
  logic [CTRL_COUNT*DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [7:0]                      tx_cmd_q, tx_cmd_d;
  logic [DATA_WIDTH-1:0]           tx_data_q, tx_data_d;
  logic                            ping_pending_q, ping_pending_d;
  logic                            lost_reported_q, lost_reported_d;
  logic                            send_ping_q;
  logic                            resp_ping_q, resp_ping_d;
  logic [CNT_W-1:0]                rst_cnt_q, rst_cnt_d;
`ifdef HEDIOS_STATS_EN
  logic [15:0]                     cmd_ok_q, cmd_ok_d;
  logic [15:0]                     cmd_err_q, cmd_err_d;
  logic                            stats_clr;
`endif

  logic                  ping_rise;
  logic                  lost_event;
  logic                  resp_err;
  logic                  slot_ok;
  logic [DATA_WIDTH-1:0] slot_sel;
  logic                  act_ok;
  logic                  ctrl_ok;

  assign ping_rise  = send_ping && !send_ping_q;
  assign lost_event = rx_lost_data && !lost_reported_q;
  assign act_ok     = data_q < DATA_WIDTH'(ACTION_COUNT);
  assign ctrl_ok    = data_q < DATA_WIDTH'(CTRL_COUNT);

  // Slot mux: full-width index compare, so oversize indices never alias.
  always_comb begin
    slot_sel = '0;
    slot_ok  = 1'b0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      if (data_q == DATA_WIDTH'(i)) begin
        slot_sel = slots[i*DATA_WIDTH +: DATA_WIDTH];
        slot_ok  = 1'b1;
      end
    end
  end

  // Next-state, response selection and command side effects.
  always_comb begin
    state_d         = state_q;
    cmd_d           = cmd_q;
    data_d          = data_q;
    last_cmd_d      = last_cmd_q;
    arg_d           = arg_q;
    ctrl_d          = ctrl_q;
    tx_cmd_d        = tx_cmd_q;
    tx_data_d       = tx_data_q;
    ping_pending_d  = ping_pending_q;
    lost_reported_d = lost_reported_q && rx_lost_data;
    resp_ping_d     = resp_ping_q;
    rst_cnt_d       = (rst_cnt_q != '0) ? rst_cnt_q - CNT_W'(1) : '0;
    rx_pop_packet   = 1'b0;
    tx_push_packet  = 1'b0;
    actions         = '0;
    resp_err        = 1'b0;
`ifdef HEDIOS_STATS_EN
    cmd_ok_d        = cmd_ok_q;
    cmd_err_d       = cmd_err_q;
    stats_clr       = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (lost_event) begin
          tx_cmd_d        = 8'hFE;
          tx_data_d       = '0;
          lost_reported_d = 1'b1;
          resp_ping_d     = 1'b0;
          state_d         = ST_RESPOND;
        end else if (ping_pending_q) begin
          tx_cmd_d    = 8'h01;
          tx_data_d   = PING_DATA;
          resp_ping_d = 1'b1;
          state_d     = ST_RESPOND;
        end else if (!rx_empty) begin
          rx_pop_packet = 1'b1;
          cmd_d         = rx_command;
          data_d        = rx_data;
          last_cmd_d    = rx_command;
          state_d       = ST_EXEC;
        end
      end

      ST_EXEC: begin
        resp_ping_d = 1'b0;
        tx_cmd_d    = cmd_q;
        tx_data_d   = data_q;
        case (cmd_q)
          8'h01: tx_data_d = PING_DATA;
          8'h02: begin
            if (slot_ok) tx_data_d = slot_sel;
            else         resp_err  = 1'b1;
          end
          8'h03: arg_d = data_q;
          8'h04: begin
            if (act_ok) begin
              for (int i = 0; i < ACTION_COUNT; i++)
                actions[i] = (data_q == DATA_WIDTH'(i));
            end else begin
              resp_err = 1'b1;
            end
          end
          8'h05: begin
            if (ctrl_ok) begin
              for (int i = 0; i < CTRL_COUNT; i++)
                if (data_q == DATA_WIDTH'(i))
                  ctrl_d[i*DATA_WIDTH +: DATA_WIDTH] = arg_q;
            end else begin
              resp_err = 1'b1;
            end
          end
          8'h06: begin
            rst_cnt_d = CNT_LOAD;
            tx_data_d = '0;
          end
`ifdef HEDIOS_STATS_EN
          8'h07: begin
            tx_data_d = DATA_WIDTH'({cmd_err_q, cmd_ok_q});
            stats_clr = 1'b1;
          end
`endif
          default: resp_err = 1'b1;
        endcase
        if (resp_err) begin
          tx_cmd_d  = 8'hFF;
          tx_data_d = {cmd_q, {(DATA_WIDTH-8){1'b0}}};
        end
`ifdef HEDIOS_STATS_EN
        if (stats_clr) begin
          cmd_ok_d  = '0;
          cmd_err_d = '0;
        end else if (resp_err) begin
          if (cmd_err_q != 16'hFFFF) cmd_err_d = cmd_err_q + 16'd1;
        end else begin
          if (cmd_ok_q != 16'hFFFF) cmd_ok_d = cmd_ok_q + 16'd1;
        end
`endif
        state_d = ST_RESPOND;
      end

      ST_RESPOND: begin
        if (!tx_full) begin
          tx_push_packet = 1'b1;
          if (resp_ping_q) ping_pending_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A fresh ping request wins over the clear of one just being pushed.
    if (ping_rise) ping_pending_d = 1'b1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cmd_q           <= '0;
      data_q          <= '0;
      last_cmd_q      <= '0;
      arg_q           <= '0;
      ctrl_q          <= '0;
      tx_cmd_q        <= '0;
      tx_data_q       <= '0;
      ping_pending_q  <= 1'b0;
      lost_reported_q <= 1'b0;
      send_ping_q     <= 1'b0;
      resp_ping_q     <= 1'b0;
      rst_cnt_q       <= '0;
`ifdef HEDIOS_STATS_EN
      cmd_ok_q        <= '0;
      cmd_err_q       <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cmd_q           <= cmd_d;
      data_q          <= data_d;
      last_cmd_q      <= last_cmd_d;
      arg_q           <= arg_d;
      ctrl_q          <= ctrl_d;
      tx_cmd_q        <= tx_cmd_d;
      tx_data_q       <= tx_data_d;
      ping_pending_q  <= ping_pending_d;
      lost_reported_q <= lost_reported_d;
      send_ping_q     <= send_ping;
      resp_ping_q     <= resp_ping_d;
      rst_cnt_q       <= rst_cnt_d;
`ifdef HEDIOS_STATS_EN
      cmd_ok_q        <= cmd_ok_d;
      cmd_err_q       <= cmd_err_d;
`endif
    end
  end

  assign tx_command      = tx_cmd_q;
  assign tx_data         = tx_data_q;
  assign action_argument = arg_q;
  assign ctrl_regs       = ctrl_q;
  assign rst_device      = (rst_cnt_q != '0);
  assign last_command    = last_cmd_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hedios_command_engine.sv
// Scoreboard bench for hedios_command_engine: a FWFT RX queue model feeds
// packets, expected responses come from a command-level reference model.
module tb_hedios_command_engine;

  localparam int DW = 32;
  localparam logic [31:0] PING = 32'h02534448;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_empty, rx_lost_data, rx_pop_packet, tx_full, tx_push_packet;
  logic [7:0]    rx_command, tx_command, last_command;
  logic [DW-1:0] rx_data, tx_data, action_argument;
  logic          send_ping, rst_device, busy;
  logic [4*DW-1:0] slots;
  logic [3:0]    actions;
  logic [2*DW-1:0] ctrl_regs;

  always #5 clk = ~clk;

  hedios_command_engine dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_lost_data(rx_lost_data),
    .rx_command(rx_command), .rx_data(rx_data), .rx_pop_packet(rx_pop_packet),
    .tx_full(tx_full), .tx_command(tx_command), .tx_data(tx_data),
    .tx_push_packet(tx_push_packet), .send_ping(send_ping), .slots(slots),
    .actions(actions), .action_argument(action_argument), .ctrl_regs(ctrl_regs),
    .rst_device(rst_device), .last_command(last_command), .busy(busy)
  );

  // Bench state: queues, reference model, counters.
  logic [39:0] rxq[$];
  logic [39:0] expq[$];
  logic [3:0]  actq[$];
  int          pop6_q[$];
  logic [31:0] slot_m[4];
  logic [31:0] arg_m;
  logic [31:0] ctrl_m[2];
  logic [15:0] st_ok, st_err;
  int passed = 0, total = 0;
  int cyc = 0, mode = 2;
  int push_cnt = 0, pop_cnt = 0, last_pop_cyc = 0, last_push_cyc = 0;
  int run_len = 0, last_len = 0, pulse_done = 0;
  bit pop_seen = 0;

  assign slots = {slot_m[3], slot_m[2], slot_m[1], slot_m[0]};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: compute the response a packet earns, then queue it.
  task automatic send(input logic [7:0] c, input logic [31:0] d);
    logic [7:0]  rc;
    logic [31:0] rd;
    bit err;
    bit counted;
    err = 0; counted = 1; rc = c; rd = d;
    case (c)
      8'h01: rd = PING;
      8'h02: if (d < 4) rd = slot_m[d[1:0]]; else err = 1;
      8'h03: arg_m = d;
      8'h04: if (d < 4) actq.push_back(4'(1 << d[1:0])); else err = 1;
      8'h05: if (d < 2) ctrl_m[d[0]] = arg_m; else err = 1;
      8'h06: rd = 0;
`ifdef HEDIOS_STATS_EN
      8'h07: begin rd = {st_err, st_ok}; st_err = 0; st_ok = 0; counted = 0; end
`endif
      default: err = 1;
    endcase
    if (err) begin
      rc = 8'hFF;
      rd = {c, 24'h0};
      if (st_err != 16'hFFFF) st_err++;
    end else if (counted) begin
      if (st_ok != 16'hFFFF) st_ok++;
    end
    expq.push_back({rc, rd});
    rxq.push_back({c, d});
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (!(rxq.size() == 0 && expq.size() == 0 && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, n < budget, 1);
  endtask

  // RX queue and tx_full driver, updated just after each active edge.
  initial begin
    rx_empty = 1'b1; rx_command = 8'h00; rx_data = '0; tx_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_seen) begin
        if (rxq.size() > 0) void'(rxq.pop_front());
        pop_seen = 0;
      end
      if (mode == 0) tx_full = ($urandom_range(0, 3) == 0);
      else           tx_full = (mode == 1);
      if (rxq.size() > 0) {rx_command, rx_data} = rxq[0];
      rx_empty = (rxq.size() == 0);
    end
  end

  // Monitor: pops the scoreboard on every push, tracks pops and pulses.
  initial begin : mon
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rx_pop_packet) begin
          chk("pop_nonempty", rx_empty, 0);
          pop_seen = 1;
          pop_cnt++;
          last_pop_cyc = cyc;
          if (rx_command == 8'h06) pop6_q.push_back(cyc);
        end
        if (tx_push_packet) begin
          push_cnt++;
          last_push_cyc = cyc;
          $display("push cyc=%0d cmd=%02h data=%08h", cyc, tx_command, tx_data);
          chk("push_txfull", tx_full, 0);
          if (expq.size() == 0) chk("push_unexpected", tx_push_packet, 0);
          else begin
            e = expq.pop_front();
            chk("tx_command", tx_command, e[39:32]);
            chk("tx_data", tx_data, e[31:0]);
          end
        end
        if (actions != 4'b0) begin
          if (actq.size() == 0) chk("actions_unexpected", actions, 0);
          else chk("actions", actions, actq.pop_front());
        end
        if (rst_device) run_len++;
        else if (run_len > 0) begin
          last_len = run_len;
          run_len = 0;
          pulse_done++;
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, pd0, p0, exp_len;
    rx_lost_data = 1'b0; send_ping = 1'b0;
    arg_m = 0; ctrl_m[0] = 0; ctrl_m[1] = 0; st_ok = 0; st_err = 0;
    slot_m[0] = $urandom; slot_m[1] = 32'h12345678;
    slot_m[2] = $urandom; slot_m[3] = $urandom;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_push", tx_push_packet, 0);
    chk("rst_pop", rx_pop_packet, 0);
    chk("rst_device", rst_device, 0);
    chk("rst_actions", actions, 0);
    chk("rst_ctrl", ctrl_regs, 0);
    chk("rst_arg", action_argument, 0);
    chk("rst_last_cmd", last_command, 0);
    chk("rst_tx", {tx_command, tx_data}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Ping packet latency: push two cycles after pop.
    mode = 2;
    send(8'h01, 0);
    drain("ping", 50);
    chk("latency", last_push_cyc - last_pop_cyc, 2);
    chk("last_command", last_command, 8'h01);

    // Argument, fire, slots, errors, control write.
    send(8'h03, 32'hDEADBEEF);
    send(8'h04, 2);
    send(8'h02, 1);
    send(8'h02, 4);
    send(8'h42, 0);
    send(8'h04, 32'h00010000);
    send(8'h03, 32'hA5);
    send(8'h05, 1);
    send(8'h05, 2);
    drain("basic", 200);
    chk("arg_a5", action_argument, 32'hA5);
    chk("ctrl1", ctrl_regs[63:32], 32'hA5);
    chk("ctrl0", ctrl_regs[31:0], 0);

    // Reset pulse length.
    pd0 = pulse_done;
    send(8'h06, 0);
    n = 0;
    while (pulse_done == pd0 && n < 100) begin @(negedge clk); n++; end
    chk("rstpulse_wait", n < 100, 1);
    chk("rstpulse_len", last_len, 16);

    // Second reset command mid-pulse extends the pulse.
    pop6_q.delete();
    pd0 = pulse_done;
    send(8'h06, 0);
    n = 0;
    while (pop6_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    send(8'h06, 0);
    n = 0;
    while (pulse_done == pd0 && n < 200) begin @(negedge clk); n++; end
    chk("rstext_wait", n < 200, 1);
    chk("rstext_pops", pop6_q.size(), 2);
    exp_len = (pop6_q.size() == 2) ? (pop6_q[1] - pop6_q[0] + 16) : 16;
    chk("rstext_len", last_len, exp_len);
    drain("rst", 50);

    // TX backpressure: response held, no further pop.
    mode = 1;
    @(negedge clk);
    n = push_cnt; p0 = pop_cnt;
    send(8'h03, 32'h11);
    send(8'h03, 32'h22);
    repeat (12) @(negedge clk);
    chk("full_no_push", push_cnt - n, 0);
    chk("full_one_pop", pop_cnt - p0, 1);
    mode = 2;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("full_release_push", push_cnt - n, 1);
    drain("full", 50);

    // Lost data outranks a simultaneous ping.
    expq.push_back({8'hFE, 32'h0});
    expq.push_back({8'h01, PING});
    @(negedge clk);
    send_ping = 1'b1;
    rx_lost_data = 1'b1;
    repeat (3) @(negedge clk);
    drain("lostping", 50);
    repeat (4) @(negedge clk);
    send_ping = 1'b0;
    rx_lost_data = 1'b0;
    chk("lostping_idle", busy, 0);

    // Randomised traffic with random backpressure.
    mode = 0;
    for (int i = 0; i < 80; i++) begin
      logic [7:0] c;
      logic [31:0] d;
      case ($urandom_range(0, 8))
        0: c = 8'h01; 1: c = 8'h02; 2: c = 8'h03; 3: c = 8'h04;
        4: c = 8'h05; 5: c = 8'h06; 6: c = 8'h07; 7: c = 8'h08;
        default: c = 8'h42;
      endcase
      d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 5)) : $urandom;
      send(c, d);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain("random", 3000);

    // Statistics readback (an error response when the feature is absent).
    send(8'h07, 0);
    send(8'h03, 1);
    send(8'h03, 2);
    send(8'h01, 0);
    send(8'h42, 0);
    send(8'h07, 0);
    send(8'h07, 0);
    drain("stats", 500);

    mode = 2;
    repeat (2) @(negedge clk);
    chk("final_arg", action_argument, arg_m);
    chk("final_ctrl0", ctrl_regs[31:0], ctrl_m[0]);
    chk("final_ctrl1", ctrl_regs[63:32], ctrl_m[1]);
    chk("final_expq", expq.size(), 0);
    chk("final_actq", actq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
